// File: rtl/keccak_rho_pi_chi_if.sv
// State-in / state-out bundle for the rho-pi-chi round slice.
// The master drives the state and its valid, and the slave returns the registered results.
interface keccak_rho_pi_chi_if #(
    parameter int STATE_SIZE = 1600
);
    logic [STATE_SIZE-1:0] IN;
    logic                  IN_VALID;
    logic [STATE_SIZE-1:0] OUT_RHO;
    logic [STATE_SIZE-1:0] OUT_PI;
    logic [STATE_SIZE-1:0] OUT;
    logic                  OUT_VALID;

    modport master (
        output IN, IN_VALID,
        input  OUT_RHO, OUT_PI, OUT, OUT_VALID
    );

    modport slave (
        input  IN, IN_VALID,
        output OUT_RHO, OUT_PI, OUT, OUT_VALID
    );
endinterface

// File: rtl/keccak_rho_pi_chi.sv
// Keccak-f[1600] rho -> pi -> chi slice: combinational steps into one output register stage.
// The rho-only and rho+pi intermediates are registered alongside the final result for debug.
module keccak_rho_pi_chi #(
    parameter int STATE_SIZE = 1600,
    parameter int LANE_W     = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    keccak_rho_pi_chi_if.slave   bus
);
    // Rotation offsets, indexed by lane number 5*y + x.
    localparam int RHO_OFF [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    logic [STATE_SIZE-1:0] rho_next;
    logic [STATE_SIZE-1:0] pi_next;
    logic [STATE_SIZE-1:0] chi_next;

    logic [STATE_SIZE-1:0] rho_reg;
    logic [STATE_SIZE-1:0] pi_reg;
    logic [STATE_SIZE-1:0] chi_reg;
    logic                  valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_lane
            localparam int X   = gi % 5;
            localparam int Y   = gi / 5;
            localparam int R   = RHO_OFF[gi];
            // Pi gathers output lane (x,y) from rho lane ((x+3y) mod 5, x).
            localparam int PI_SRC = 5 * X + ((X + 3 * Y) % 5);
            localparam int CHI_1  = 5 * Y + ((X + 1) % 5);
            localparam int CHI_2  = 5 * Y + ((X + 2) % 5);

            logic [LANE_W-1:0]   lane_in;
            logic [2*LANE_W-1:0] lane_dbl;

            assign lane_in  = bus.IN[LANE_W*gi +: LANE_W];
            // Rotate left by R: the upper half of the doubled lane shifted by R, safe for R = 0.
            assign lane_dbl = {lane_in, lane_in} << R;
            assign rho_next[LANE_W*gi +: LANE_W] = lane_dbl[2*LANE_W-1 -: LANE_W];

            assign pi_next[LANE_W*gi +: LANE_W] = rho_next[LANE_W*PI_SRC +: LANE_W];

            assign chi_next[LANE_W*gi +: LANE_W] =
                pi_next[LANE_W*gi +: LANE_W] ^
                (~pi_next[LANE_W*CHI_1 +: LANE_W] & pi_next[LANE_W*CHI_2 +: LANE_W]);
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            rho_reg   <= '0;
            pi_reg    <= '0;
            chi_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                rho_reg <= rho_next;
                pi_reg  <= pi_next;
                chi_reg <= chi_next;
            end
        end
    end

    assign bus.OUT_RHO   = rho_reg;
    assign bus.OUT_PI    = pi_reg;
    assign bus.OUT       = chi_reg;
    assign bus.OUT_VALID = valid_reg;
endmodule

// File: tb/tb_keccak_rho_pi_chi.sv
// Scoreboard bench for keccak_rho_pi_chi: the driver queues expected results, the monitor pops them on OUT_VALID.
// Directed vectors carry hand-computed results; sweeps use an independent bit-level reference.
module tb_keccak_rho_pi_chi;
    localparam int SS = 1600;

    typedef struct packed {
        logic [SS-1:0] rho;
        logic [SS-1:0] pi;
        logic [SS-1:0] chi;
    } exp_t;

    logic clk;
    logic rst;
    keccak_rho_pi_chi_if #(.STATE_SIZE(SS)) bus ();

    keccak_rho_pi_chi #(.STATE_SIZE(SS), .LANE_W(64)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    exp_t sb_q [$];
    exp_t last_exp;

    // Offsets indexed [x][y].
    int ro [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    function automatic exp_t model(input logic [SS-1:0] st);
        exp_t e;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    e.rho[64*(5*y+x)+z] = st[64*(5*y+x) + ((z - ro[x][y] + 64) % 64)];
        // Scatter form: input lane (x,y) lands at (y, (2x+3y) mod 5).
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    e.pi[64*(5*((2*x+3*y)%5)+y)+z] = e.rho[64*(5*y+x)+z];
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int z = 0; z < 64; z++)
                    e.chi[64*(5*y+x)+z] = e.pi[64*(5*y+x)+z] ^
                        (~e.pi[64*(5*y+(x+1)%5)+z] & e.pi[64*(5*y+(x+2)%5)+z]);
        return e;
    endfunction

    function automatic int first_diff_lane(input logic [SS-1:0] a, input logic [SS-1:0] b);
        for (int i = 0; i < 25; i++)
            if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        return 0;
    endfunction

    task automatic check_state(input string name, input logic [SS-1:0] act, input logic [SS-1:0] req);
        int l;
        checks++;
        if (act !== req) begin
            errors++;
            l = first_diff_lane(act, req);
            $display("FAIL %s lane %0d actual %h required %h", name, l, act[64*l +: 64], req[64*l +: 64]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %b required %b", name, act, req);
        end
    endtask

    // One input cycle; the valid flag must follow the accepted-input rule one edge later.
    task automatic apply(input logic [SS-1:0] st, input logic v, input logic r, input exp_t e);
        if (v && !r) begin
            sb_q.push_back(e);
            last_exp = e;
        end
        bus.IN       = st;
        bus.IN_VALID = v;
        rst          = r;
        @(posedge clk);
        #1;
        check_bit("out_valid", bus.OUT_VALID, v && !r);
    endtask

    task automatic check_zero(input string name);
        check_state({name, "_rho"}, bus.OUT_RHO, '0);
        check_state({name, "_pi"},  bus.OUT_PI,  '0);
        check_state({name, "_chi"}, bus.OUT,     '0);
    endtask

    // Monitor: each presented result must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.OUT_VALID === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid actual 1 required 0 (no pending input)");
                end else begin
                    e = sb_q.pop_front();
                    check_state("sb_rho", bus.OUT_RHO, e.rho);
                    check_state("sb_pi",  bus.OUT_PI,  e.pi);
                    check_state("sb_chi", bus.OUT,     e.chi);
                    $display("txn %0d compared", txn);
                    txn++;
                end
            end
        end
    end

    initial begin
        logic [SS-1:0] ones;
        logic [SS-1:0] st;
        exp_t          e;
        exp_t          dummy;

        ones  = '1;
        dummy = '0;
        bus.IN       = '0;
        bus.IN_VALID = 1'b0;
        rst          = 1'b1;

        // Reset has priority over a valid all-ones input.
        for (int i = 0; i < 2; i++) begin
            apply(ones, 1'b1, 1'b1, dummy);
            check_zero("reset");
        end

        e = '0;
        apply('0, 1'b1, 1'b0, e);
        e.rho = ones; e.pi = ones; e.chi = ones;
        apply(ones, 1'b1, 1'b0, e);

        // lane(0,0) z=0.
        st = '0; st[0] = 1'b1;
        e  = '0; e.rho[0] = 1'b1; e.pi[0] = 1'b1; e.chi[0] = 1'b1; e.chi[192] = 1'b1;
        apply(st, 1'b1, 1'b0, e);

        // lane(1,0) z=0.
        st = '0; st[64] = 1'b1;
        e  = '0; e.rho[65] = 1'b1; e.pi[641] = 1'b1; e.chi[641] = 1'b1; e.chi[833] = 1'b1;
        apply(st, 1'b1, 1'b0, e);

        // Hold: outputs keep the last result while IN_VALID is low.
        for (int i = 0; i < 2; i++) begin
            apply(ones, 1'b0, 1'b0, dummy);
            check_state("hold_rho", bus.OUT_RHO, last_exp.rho);
            check_state("hold_pi",  bus.OUT_PI,  last_exp.pi);
            check_state("hold_chi", bus.OUT,     last_exp.chi);
        end

        // Random states back-to-back.
        for (int n = 0; n < 24; n++) begin
            for (int k = 0; k < SS / 32; k++) st[32*k +: 32] = $urandom;
            apply(st, 1'b1, 1'b0, model(st));
        end

        // Reset mid-stream drops the concurrent input; the next input is processed normally.
        apply(ones, 1'b1, 1'b1, dummy);
        check_zero("midrst");
        st = '0; st[64] = 1'b1;
        e  = '0; e.rho[65] = 1'b1; e.pi[641] = 1'b1; e.chi[641] = 1'b1; e.chi[833] = 1'b1;
        apply(st, 1'b1, 1'b0, e);

        // Every single-bit input, back-to-back.
        for (int b = 0; b < SS; b++) begin
            st    = '0;
            st[b] = 1'b1;
            apply(st, 1'b1, 1'b0, model(st));
        end

        apply('0, 1'b0, 1'b0, dummy);
        apply('0, 1'b0, 1'b0, dummy);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual %0d pending required 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keccak_rho_pi_chi.md
Name: keccak_rho_pi_chi

Overview:
- Registered Keccak-f[1600] round datapath slice that applies the rho, pi and chi step mappings, in that order, to a full 1600-bit state.
- Sits between the theta stage and the iota/round-constant stage of the SHA3 permutation core.
- Also exposes registered rho-only and rho+pi intermediate results for debug and stage-level verification.

Parameters:
- STATE_SIZE, 1600, state width in bits; only 1600 is legal.
- LANE_W, 64, lane width in bits; only 64 is legal. STATE_SIZE = 25*LANE_W.

Ports:
- CLK  input  1  single clock; all flops are rising-edge.
- RST  input  1  synchronous, active-high reset.
- IN  input  STATE_SIZE  input state.
- IN_VALID  input  1  qualifies IN; capture happens on CLK rising edge when high.
- OUT_RHO  output  STATE_SIZE  registered rho(IN).
- OUT_PI  output  STATE_SIZE  registered pi(rho(IN)).
- OUT  output  STATE_SIZE  registered chi(pi(rho(IN))).
- OUT_VALID  output  1  high for exactly the cycle after each accepted IN.

Behaviour:
- State layout: lane (x,y), x,y in 0..4, occupies bits [64*(5y+x) +: 64]. Bit z of the lane is bit 64*(5y+x)+z. The state is LSB-first: z=0 is the LSB of the lane.
- Rho: out(x,y,z) = in(x,y,(z - r[x][y]) mod 64), i.e. each lane is rotated left toward higher z.
  - Rotation offsets r[x][y], listed per x for y=0..4:
  - x=0: 0,36,3,41,18
  - x=1: 1,44,10,45,2
  - x=2: 62,6,43,15,61
  - x=3: 28,55,25,21,56
  - x=4: 27,20,39,8,14
- Pi: out lane(x,y) = in lane((x+3y) mod 5, x). Equivalently, in lane(x,y) moves to out lane(y, (2x+3y) mod 5).
- Chi, per row y and bit z: out(x) = a(x) XOR (NOT a((x+1) mod 5) AND a((x+2) mod 5)).
- The three steps are pure combinational logic between the IN port and the output registers. There are no internal pipeline registers.
- Latency is 1 cycle.
  - If IN_VALID=1 at edge k, then from edge k onward: OUT_RHO, OUT_PI and OUT reflect that IN, and OUT_VALID=1.
- If IN_VALID=0 at an edge, the OUT_RHO, OUT_PI and OUT registers hold their values and OUT_VALID goes to 0.
- Back-to-back IN_VALID is supported at one state per cycle. There is no backpressure.
- Reset: when RST=1 at an edge, OUT_RHO, OUT_PI and OUT are set to all-zero and OUT_VALID to 0.
  - RST has priority over IN_VALID; an input presented in the same cycle is dropped.
  - Reset mid-stream discards the pending result with no residual state.
- X-free: the outputs depend only on captured IN. There are no uninitialised registers after reset.

Test Plan:
- Reset: drive RST=1 for 2 cycles with IN=all-ones and IN_VALID=1 -> OUT_RHO=OUT_PI=OUT=0 and OUT_VALID=0 throughout.
- All-zero / all-ones: IN=0 with valid -> all three outputs 0 next cycle. IN=all-ones -> all three outputs all-ones and OUT_VALID=1.
- Single bit at lane(0,0) z=0: IN bit 0 = 1 -> OUT_RHO bit 0 only, OUT_PI bit 0 only, OUT bits 0 and 192 set, everything else 0.
- Single bit at lane(1,0) z=0: IN bit 64 = 1 -> OUT_RHO bit 65 only, OUT_PI bit 641 only, OUT bits 641 and 833 set, everything else 0.
- Full sweep: random states and all 1600 single-bit inputs, back-to-back with IN_VALID=1 -> each output matches a golden model one cycle later and OUT_VALID stays 1.
- Hold and reset mid-stream: deassert IN_VALID -> outputs hold and OUT_VALID=0. Assert RST while IN_VALID=1 -> zeros next cycle. Release RST -> the next valid input is processed normally.
